// File: rtl/noc_local_ni.sv
// Generic single-clock FIFO: push refused when full (even with a same-cycle pop), pop ignored when empty.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: the caller watches count; illegal push/pop requests are silently ignored.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           popData,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             wrEn;
    logic             rdEn;

    assign wrEn    = push && (count != FULL_LVL);
    assign rdEn    = pop && (count != '0);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + AW'(1);
            if (rdEn) rdPtr <= rdPtr + AW'(1);
            case ({wrEn, rdEn})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Local network interface: packs core messages into router flits and filters router flits into a receive FIFO.
// Latency: tx accept -> inj_write one edge later; ej_write push -> rx_valid one edge later.
// Backpressure: tx_ready from registered router full/almost-full; ej_full/ej_almost_full from FIFO fill.
module noc_local_ni #(
    parameter int         WIDTH    = 16,
    parameter int         RX_DEPTH = 8,
    parameter logic [1:0] LOCAL_IP = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [1:0]       tx_dst,
    input  logic [WIDTH-4:0] tx_payload,
    output logic             tx_ready,
    output logic [WIDTH-1:0] inj_data,
    output logic             inj_write,
    input  logic             inj_full,
    input  logic             inj_almost_full,
    input  logic [WIDTH-1:0] ej_data,
    input  logic             ej_write,
    output logic             ej_full,
    output logic             ej_almost_full,
    output logic             rx_valid,
    output logic [WIDTH-4:0] rx_payload,
    input  logic             rx_ready,
    output logic [15:0]      tx_count,
    output logic [15:0]      rx_count,
    output logic [15:0]      drop_count
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] FULL_LVL   = (AW+1)'(RX_DEPTH);
    localparam logic [AW:0] ALMOST_LVL = (AW+1)'(RX_DEPTH - 1);

    logic          sendOk;
    logic          txAccept;
    logic          flitVld;
    logic          destHit;
    logic          rxPush;
    logic          rxDrop;
    logic          rxPop;
    logic [AW:0]   fill;

    assign tx_ready = sendOk;
    assign txAccept = tx_valid & sendOk;

    // One-cycle lookahead: an in-flight write against an almost-full router may fill it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sendOk    <= 1'b0;
            inj_write <= 1'b0;
            inj_data  <= '0;
        end else begin
            sendOk    <= ~(inj_full | (inj_almost_full & inj_write));
            inj_write <= txAccept;
            inj_data  <= txAccept ? {tx_payload, tx_dst, 1'b1} : '0;
        end
    end

    assign flitVld = ej_write & ej_data[0];
    assign destHit = (ej_data[2:1] == LOCAL_IP);
    assign rxPush  = flitVld & destHit & ~ej_full;
    assign rxDrop  = flitVld & ~rxPush;
    assign rxPop   = rx_ready & rx_valid;

    fifo #(
        .WIDTH (WIDTH - 3),
        .DEPTH (RX_DEPTH)
    ) rxFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rxPush),
        .pushData (ej_data[WIDTH-1:3]),
        .pop      (rxPop),
        .popData  (rx_payload),
        .count    (fill)
    );

    assign ej_full        = (fill == FULL_LVL);
    assign ej_almost_full = (fill >= ALMOST_LVL);
    assign rx_valid       = (fill != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count   <= '0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (inj_write && tx_count != 16'hFFFF)  tx_count   <= tx_count + 16'd1;
            if (rxPush && rx_count != 16'hFFFF)     rx_count   <= rx_count + 16'd1;
            if (rxDrop && drop_count != 16'hFFFF)   drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni: reset, injection, backpressure, receive FIFO fill/drain, drops, mid-run reset.
module tb_noc_local_ni;
    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [1:0]  tx_dst;
    logic [12:0] tx_payload;
    logic        tx_ready;
    logic [15:0] inj_data;
    logic        inj_write;
    logic        inj_full;
    logic        inj_almost_full;
    logic [15:0] ej_data;
    logic        ej_write;
    logic        ej_full;
    logic        ej_almost_full;
    logic        rx_valid;
    logic [12:0] rx_payload;
    logic        rx_ready;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    noc_local_ni #(.WIDTH(16), .RX_DEPTH(8), .LOCAL_IP(2'b00)) dut (
        .clk             (clk),
        .reset           (reset),
        .tx_valid        (tx_valid),
        .tx_dst          (tx_dst),
        .tx_payload      (tx_payload),
        .tx_ready        (tx_ready),
        .inj_data        (inj_data),
        .inj_write       (inj_write),
        .inj_full        (inj_full),
        .inj_almost_full (inj_almost_full),
        .ej_data         (ej_data),
        .ej_write        (ej_write),
        .ej_full         (ej_full),
        .ej_almost_full  (ej_almost_full),
        .rx_valid        (rx_valid),
        .rx_payload      (rx_payload),
        .rx_ready        (rx_ready),
        .tx_count        (tx_count),
        .rx_count        (rx_count),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; tx_valid = 1'b0; tx_dst = 2'b00; tx_payload = '0;
        inj_full = 1'b0; inj_almost_full = 1'b0; ej_data = '0; ej_write = 1'b0; rx_ready = 1'b0;
        tick(); tick();
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%0h exp=0", tx_ready); end
        total++; if (inj_write !== 1'b0) begin bad++; $display("FAIL reset_inj_write got=%0h exp=0", inj_write); end
        total++; if (inj_data !== 16'h0000) begin bad++; $display("FAIL reset_inj_data got=%h exp=0000", inj_data); end
        total++; if ({rx_valid, ej_full, ej_almost_full} !== 3'b000) begin bad++; $display("FAIL reset_rx_flags got=%b exp=000", {rx_valid, ej_full, ej_almost_full}); end
        total++; if ({tx_count, rx_count, drop_count} !== 48'h0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {tx_count, rx_count, drop_count}); end
        reset = 1'b1;
        tick();
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL release_tx_ready got=%0h exp=1", tx_ready); end
    endtask

    task automatic test_tx_basic();
        tx_valid = 1'b1; tx_dst = 2'b01; tx_payload = 13'h0ABC;
        tick();
        tx_valid = 1'b0;
        total++; if (inj_write !== 1'b1) begin bad++; $display("FAIL basic_inj_write got=%0h exp=1", inj_write); end
        total++; if (inj_data !== 16'h55E3) begin bad++; $display("FAIL basic_inj_data got=%h exp=55e3", inj_data); end
        tick();
        total++; if (inj_write !== 1'b0) begin bad++; $display("FAIL basic_idle_write got=%0h exp=0", inj_write); end
        total++; if (inj_data !== 16'h0000) begin bad++; $display("FAIL basic_idle_data got=%h exp=0000", inj_data); end
        total++; if (tx_count !== 16'd1) begin bad++; $display("FAIL basic_tx_count got=%0d exp=1", tx_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expData [3];
        expData[0] = 16'h0009; expData[1] = 16'h0011; expData[2] = 16'h0019;
        tx_valid = 1'b1; tx_dst = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tx_payload = 13'(i + 1);
            tick();
            total++; if ({inj_write, inj_data} !== {1'b1, expData[i]}) begin bad++; $display("FAIL b2b_flit%0d got=%0h/%h exp=1/%h", i, inj_write, inj_data, expData[i]); end
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%0h exp=1", i, tx_ready); end
        end
        tx_valid = 1'b0;
        tick();
        total++; if (inj_write !== 1'b0) begin bad++; $display("FAIL b2b_end_write got=%0h exp=0", inj_write); end
        total++; if (tx_count !== 16'd4) begin bad++; $display("FAIL b2b_tx_count got=%0d exp=4", tx_count); end
    endtask

    task automatic test_backpressure();
        inj_almost_full = 1'b1; tx_valid = 1'b1; tx_dst = 2'b01; tx_payload = 13'h0005;
        tick();
        tx_valid = 1'b0;
        total++; if ({inj_write, inj_data} !== {1'b1, 16'h002B}) begin bad++; $display("FAIL af_flit got=%0h/%h exp=1/002b", inj_write, inj_data); end
        tick();
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL af_tx_ready got=%0h exp=0", tx_ready); end
        inj_almost_full = 1'b0; inj_full = 1'b1; tx_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if ({tx_ready, inj_write} !== 2'b00) begin bad++; $display("FAIL full_hold%0d ready/write got=%b exp=00", i, {tx_ready, inj_write}); end
        end
        inj_full = 1'b0;
        tick();
        total++; if ({tx_ready, inj_write} !== 2'b10) begin bad++; $display("FAIL full_release ready/write got=%b exp=10", {tx_ready, inj_write}); end
        tick();
        tx_valid = 1'b0;
        total++; if ({inj_write, inj_data} !== {1'b1, 16'h002B}) begin bad++; $display("FAIL full_resume got=%0h/%h exp=1/002b", inj_write, inj_data); end
        tick();
        total++; if (tx_count !== 16'd6) begin bad++; $display("FAIL bp_tx_count got=%0d exp=6", tx_count); end
    endtask

    task automatic test_rx_fill();
        rx_ready = 1'b0; ej_write = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            ej_data = {13'(16 + k), 2'b00, 1'b1};
            tick();
            total++; if ({ej_almost_full, ej_full} !== {k >= 7, k == 8}) begin bad++; $display("FAIL fill%0d af/full got=%b exp=%b", k, {ej_almost_full, ej_full}, {k >= 7, k == 8}); end
            total++; if (rx_count !== 16'(k)) begin bad++; $display("FAIL fill%0d rx_count got=%0d exp=%0d", k, rx_count, k); end
        end
        total++; if ({rx_valid, rx_payload} !== {1'b1, 13'h0011}) begin bad++; $display("FAIL fill_head got=%0h/%h exp=1/0011", rx_valid, rx_payload); end
        ej_data = {13'h0019, 2'b00, 1'b1};
        tick();
        ej_write = 1'b0;
        total++; if ({drop_count, rx_count} !== {16'd1, 16'd8}) begin bad++; $display("FAIL fill_overflow drop/rx got=%0d/%0d exp=1/8", drop_count, rx_count); end
        total++; if (ej_full !== 1'b1) begin bad++; $display("FAIL fill_overflow_full got=%0h exp=1", ej_full); end
    endtask

    task automatic test_full_pushpop();
        ej_write = 1'b1; ej_data = {13'h001A, 2'b00, 1'b1}; rx_ready = 1'b1;
        tick();
        ej_write = 1'b0;
        total++; if ({ej_full, ej_almost_full} !== 2'b01) begin bad++; $display("FAIL pp_full full/af got=%b exp=01", {ej_full, ej_almost_full}); end
        total++; if ({rx_count, drop_count} !== {16'd8, 16'd2}) begin bad++; $display("FAIL pp_full rx/drop got=%0d/%0d exp=8/2", rx_count, drop_count); end
        for (int i = 0; i < 7; i++) begin
            total++; if ({rx_valid, rx_payload} !== {1'b1, 13'(18 + i)}) begin bad++; $display("FAIL drain%0d got=%0h/%h exp=1/%h", i, rx_valid, rx_payload, 13'(18 + i)); end
            tick();
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0h exp=0", rx_valid); end
        tick();
        total++; if ({rx_valid, ej_full, ej_almost_full} !== 3'b000) begin bad++; $display("FAIL empty_pop got=%b exp=000", {rx_valid, ej_full, ej_almost_full}); end
        rx_ready = 1'b0; ej_write = 1'b1; ej_data = {13'h0021, 2'b00, 1'b1};
        tick();
        rx_ready = 1'b1; ej_data = {13'h0022, 2'b00, 1'b1};
        tick();
        ej_write = 1'b0;
        total++; if ({rx_valid, rx_payload, ej_almost_full} !== {1'b1, 13'h0022, 1'b0}) begin bad++; $display("FAIL mid_pushpop got=%0h/%h/%0h exp=1/0022/0", rx_valid, rx_payload, ej_almost_full); end
        total++; if (rx_count !== 16'd10) begin bad++; $display("FAIL mid_rx_count got=%0d exp=10", rx_count); end
        tick();
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_final_pop got=%0h exp=0", rx_valid); end
    endtask

    task automatic test_drop();
        ej_write = 1'b1; ej_data = 16'h0005;
        tick();
        total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL drop_wrong_dst got=%0d exp=3", drop_count); end
        ej_data = 16'h0004;
        tick();
        ej_data = 16'h0008;
        tick();
        ej_write = 1'b0;
        total++; if ({drop_count, rx_count} !== {16'd3, 16'd10}) begin bad++; $display("FAIL drop_invalid drop/rx got=%0d/%0d exp=3/10", drop_count, rx_count); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL drop_rx_valid got=%0h exp=0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        ej_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ej_data = {13'(48 + k), 2'b00, 1'b1};
            tick();
        end
        ej_write = 1'b0;
        tx_valid = 1'b1; tx_dst = 2'b10; tx_payload = 13'h0001;
        tick();
        total++; if ({rx_valid, inj_write} !== 2'b11) begin bad++; $display("FAIL pre_reset valid/write got=%b exp=11", {rx_valid, inj_write}); end
        #2 reset = 1'b0;
        #1;
        total++; if ({rx_valid, inj_write, tx_ready, ej_almost_full} !== 4'b0000) begin bad++; $display("FAIL async_reset flags got=%b exp=0000", {rx_valid, inj_write, tx_ready, ej_almost_full}); end
        total++; if ({inj_data, tx_count, rx_count, drop_count} !== 64'h0) begin bad++; $display("FAIL async_reset data/counters got=%h exp=0", {inj_data, tx_count, rx_count, drop_count}); end
        tx_valid = 1'b0;
        #1 reset = 1'b1;
        tick();
        total++; if ({rx_valid, tx_ready, inj_write} !== 3'b010) begin bad++; $display("FAIL post_reset valid/ready/write got=%b exp=010", {rx_valid, tx_ready, inj_write}); end
        total++; if (rx_count !== 16'd0) begin bad++; $display("FAIL post_reset rx_count got=%0d exp=0", rx_count); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_back_to_back();
        test_backpressure();
        test_rx_fill();
        test_full_pushpop();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
